// File: rtl/instruction_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instruction_cache                                             |
// | Purpose  : Direct-mapped read-only instruction cache. Returns the 32-bit |
// |            word for PC in the same cycle on a hit. On a miss it stalls   |
// |            with BUSYWAIT and fills one block from instruction memory.    |
// | Options  : ICACHE_STATS_EN adds saturating hit_count/miss_count outputs. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instruction_cache #(
   parameter int ADDR_W  = 10,
   parameter int INDEX_W = 3,
   parameter int WOFF_W  = 2
) (
   input  logic                               CLK,
   input  logic                               RESET,
   input  logic [31:0]                        PC,
   output logic [31:0]                        INSTRUCTION,
   output logic                               BUSYWAIT,
   output logic                               mem_read,
   output logic [ADDR_W-WOFF_W-3:0]           mem_address,
   input  logic [32*(2**WOFF_W)-1:0]          mem_readdata,
   input  logic                               mem_busywait
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]                        hit_count,
   output logic [15:0]                        miss_count
`endif
);

   localparam int c_TAG_W  = ADDR_W - INDEX_W - WOFF_W - 2;
   localparam int c_BLK_W  = c_TAG_W + INDEX_W;
   localparam int c_LINES  = 2**INDEX_W;
   localparam int c_LINE_W = 32 * (2**WOFF_W);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_READ = 2'd1,
      S_UPDATE   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [c_LINES-1:0]    r_valid;
   logic [c_TAG_W-1:0]    r_tags [c_LINES];
   logic [c_LINE_W-1:0]   r_data [c_LINES];

   logic [c_BLK_W-1:0]    r_miss_addr;
   logic [c_LINE_W-1:0]   r_fill_data;

   logic [WOFF_W-1:0]     w_offset;
   logic [INDEX_W-1:0]    w_index;
   logic [c_TAG_W-1:0]    w_tag;
   logic                  w_hit;
   logic [c_LINE_W-1:0]   w_line;
   logic [31:0]           w_word;
   logic [INDEX_W-1:0]    w_fill_index;
   logic [c_TAG_W-1:0]    w_fill_tag;

   // Upper PC bits wrap the address space and PC[1:0] is always word-aligned.
   logic                  w_unused;
   assign w_unused = &{1'b0, PC[31:ADDR_W], PC[1:0]};

   // Address split and hit detection for the current fetch address.
   assign w_offset     = PC[WOFF_W+1:2];
   assign w_index      = PC[WOFF_W+INDEX_W+1:WOFF_W+2];
   assign w_tag        = PC[ADDR_W-1:ADDR_W-c_TAG_W];
   assign w_hit        = r_valid[w_index] && (r_tags[w_index] == w_tag);
   assign w_line       = r_data[w_index];
   assign w_word       = w_line[32*w_offset +: 32];
   assign w_fill_index = r_miss_addr[INDEX_W-1:0];
   assign w_fill_tag   = r_miss_addr[c_BLK_W-1:INDEX_W];

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and output decode; outputs come from the registered state
   // and miss register, so mem_read/mem_address stay glitch-free in MEM_READ.
   always_comb begin
      w_state_next = r_state;
      INSTRUCTION  = 32'h0;
      BUSYWAIT     = 1'b0;
      mem_read     = 1'b0;
      mem_address  = '0;
      case (r_state)
         S_IDLE: begin
            if (!w_hit) begin
               w_state_next = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            if (!mem_busywait) begin
               w_state_next = S_UPDATE;
            end
         end
         S_UPDATE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (!RESET) begin
         INSTRUCTION = w_word;
         case (r_state)
            S_IDLE: begin
               BUSYWAIT = !w_hit;
            end
            S_MEM_READ: begin
               BUSYWAIT    = 1'b1;
               mem_read    = 1'b1;
               mem_address = r_miss_addr;
            end
            S_UPDATE: begin
               BUSYWAIT = 1'b1;
            end
            default: begin
               BUSYWAIT = 1'b0;
            end
         endcase
      end
   end

   // Latch the missing block address when leaving IDLE.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_miss_addr <= '0;
      end else if (r_state == S_IDLE && !w_hit) begin
         r_miss_addr <= {w_tag, w_index};
      end
   end

   // Capture the memory block on the cycle memory releases busywait.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_fill_data <= '0;
      end else if (r_state == S_MEM_READ && !mem_busywait) begin
         r_fill_data <= mem_readdata;
      end
   end

   // Valid bits: cleared by reset, set when a fill is written.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_valid <= '0;
      end else if (r_state == S_UPDATE) begin
         r_valid[w_fill_index] <= 1'b1;
      end
   end

   // Tag and data storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge CLK) begin
      if (!RESET && r_state == S_UPDATE) begin
         r_tags[w_fill_index] <= w_fill_tag;
         r_data[w_fill_index] <= r_fill_data;
      end
   end

`ifdef ICACHE_STATS_EN
   // Saturating hit/miss statistics.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_count  <= 16'h0;
         miss_count <= 16'h0;
      end else if (r_state == S_IDLE) begin
         if (w_hit && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
         end
         if (!w_hit && miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instruction_cache                                          |
// | Purpose  : Self-checking bench for instruction_cache: directed scenarios |
// |            followed by random fetches against a residency model.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_instruction_cache;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic [31:0]   PC = 32'h0;
   logic [31:0]   INSTRUCTION;
   logic          BUSYWAIT;
   logic          mem_read;
   logic [5:0]    mem_address;
   logic [127:0]  mem_readdata = '0;
   logic          mem_busywait = 1'b0;
`ifdef ICACHE_STATS_EN
   logic [15:0]   hit_count;
   logic [15:0]   miss_count;
`endif

   instruction_cache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PC           (PC),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   // Backing memory: 64 blocks of 4 words.
   logic [127:0] blocks [64];
   int           force_lat = -1;
   int           cur_lat   = 0;
   bit           active    = 1'b0;
   int           cnt       = 0;

   int           n_checks  = 0;
   int           n_pass    = 0;

   // Residency model: which block each line holds.
   bit           m_valid [8];
   logic [5:0]   m_blk   [8];

   // Instruction memory: busy for cur_lat cycles per request, then data.
   always @(negedge CLK) begin
      if (mem_read) begin
         if (!active) begin
            active  = 1'b1;
            cnt     = 0;
            cur_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
         end
         if (cnt < cur_lat) begin
            mem_busywait = 1'b1;
            cnt++;
         end else begin
            mem_busywait = 1'b0;
            mem_readdata = blocks[mem_address];
         end
      end else begin
         active       = 1'b0;
         mem_busywait = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] golden(input logic [31:0] pc);
      logic [127:0] b;
      b = blocks[pc[9:4]];
      return b[32*pc[3:2] +: 32];
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      return m_valid[pc[6:4]] && (m_blk[pc[6:4]] == pc[9:4]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_blk[i]   = '0;
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_busywait", {31'b0, BUSYWAIT}, 32'h0);
      check("rst_mem_read", {31'b0, mem_read}, 32'h0);
      check("rst_mem_address", {26'b0, mem_address}, 32'h0);
      check("rst_instruction", INSTRUCTION, 32'h0);
   endtask

   // One fetch: present PC, expect hit/miss per model, wait out any stall.
   // A miss stalls for the detect cycle, cur_lat busy cycles plus the data
   // cycle in MEM_READ, and the UPDATE cycle: cur_lat + 3 cycles in total.
   task automatic fetch(input logic [31:0] pc, input bit skip_edge);
      int n;
      bit exp_hit;
      bit addr_seen;
      if (!skip_edge) begin
         @(posedge CLK);
         #1;
      end
      PC      = pc;
      exp_hit = model_hit(pc);
      @(negedge CLK);
      check("busywait_first", {31'b0, BUSYWAIT}, exp_hit ? 32'h0 : 32'h1);
      n = 0;
      addr_seen = 1'b0;
      while (BUSYWAIT && n < 60) begin
         n++;
         if (mem_read && !addr_seen) begin
            addr_seen = 1'b1;
            check("mem_address", {26'b0, mem_address}, {26'b0, pc[9:4]});
         end
         @(negedge CLK);
      end
      if (!exp_hit) begin
         check("miss_mem_read_seen", {31'b0, addr_seen}, 32'h1);
         check("miss_penalty", n, cur_lat + 3);
         m_valid[pc[6:4]] = 1'b1;
         m_blk[pc[6:4]]   = pc[9:4];
      end
      check("busywait_done", {31'b0, BUSYWAIT}, 32'h0);
      check("instruction", INSTRUCTION, golden(pc));
      check("mem_read_idle", {31'b0, mem_read}, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n;
      bit   saw2;
      bit   saw3;
      logic [31:0] pc;

      for (int i = 0; i < 64; i++) begin
         blocks[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      blocks[0][31:0] = 32'h07030F00;
      model_clear();

      // Reset state.
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_reset_outputs();

      // Cold miss with a 5-cycle memory latency, then sequential hits.
      force_lat = 5;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      fetch(32'h0, 1'b1);
      check("cold_word0", INSTRUCTION, 32'h07030F00);
      fetch(32'h4, 1'b0);
      fetch(32'h8, 1'b0);
      fetch(32'hC, 1'b0);
`ifdef ICACHE_STATS_EN
      @(posedge CLK);
      #1;
      check("stats_miss", {16'b0, miss_count}, 32'd1);
      check("stats_hit", {16'b0, hit_count}, 32'd4);
`endif

      // Conflict eviction on index 0.
      force_lat = -1;
      fetch(32'h080, 1'b0);
      fetch(32'h000, 1'b0);
      fetch(32'h080, 1'b0);

      // Reset in the middle of a fill.
      force_lat = 4;
      @(posedge CLK);
      #1;
      PC = 32'h10;
      n = 0;
      while (!mem_read && n < 10) begin
         @(negedge CLK);
         n++;
      end
      check("midfill_mem_read", {31'b0, mem_read}, 32'h1);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      model_clear();
      @(negedge CLK);
      check_reset_outputs();
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      fetch(32'h10, 1'b1);

      // PC moves during a fill: first block completes, then a second miss.
      force_lat = 3;
      @(posedge CLK);
      #1;
      PC = 32'h20;
      n = 0;
      while (!mem_read && n < 10) begin
         @(negedge CLK);
         n++;
      end
      check("pcchg_first_addr", {26'b0, mem_address}, 32'h2);
      @(posedge CLK);
      #1;
      PC = 32'h30;
      saw2 = 1'b0;
      saw3 = 1'b0;
      n = 0;
      @(negedge CLK);
      while (BUSYWAIT && n < 60) begin
         if (mem_read && mem_address == 6'h02) saw2 = 1'b1;
         if (mem_read && mem_address == 6'h03) saw3 = 1'b1;
         n++;
         @(negedge CLK);
      end
      check("pcchg_kept_fill", {31'b0, saw2}, 32'h1);
      check("pcchg_second_miss", {31'b0, saw3}, 32'h1);
      check("pcchg_busywait", {31'b0, BUSYWAIT}, 32'h0);
      check("pcchg_instruction", INSTRUCTION, golden(32'h30));
      m_valid[2] = 1'b1;
      m_blk[2]   = 6'h02;
      m_valid[3] = 1'b1;
      m_blk[3]   = 6'h03;
      fetch(32'h20, 1'b0);

      // Random fetches: two tags over four indices for plenty of conflicts,
      // with random ignored upper and low PC bits.
      force_lat = -1;
      for (int k = 0; k < 80; k++) begin
         pc      = $urandom;
         pc[9:7] = 3'($urandom_range(0, 1));
         pc[6:4] = 3'($urandom_range(0, 3));
         fetch(pc, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
